// File: rtl/slip_rx_fifo_if.sv
// Byte-stream handshake bundle for slip_rx_fifo: encoded input side and decoded output side.
interface slip_rx_fifo_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       out_err;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_err
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, out_err
    );
endinterface

// File: rtl/slip_rx_fifo.sv
// SLIP receive deframer with first-word fall-through output FIFO and last/err tagging.
// Optional SLIP_RX_STATS_EN adds saturating frame_cnt / err_cnt outputs.
module slip_rx_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MAX_LEN = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    slip_rx_fifo_if.slave              bus,
    output logic                       frame_start,
    output logic                       frame_end,
    output logic                       frame_error,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
`ifdef SLIP_RX_STATS_EN
    ,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CNT_W-1:0]           err_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned NW = $clog2(MAX_LEN + 1);
    localparam logic [NW-1:0] MaxLen  = NW'(MAX_LEN);
    localparam logic [7:0]    ByteEnd = 8'hC0;
    localparam logic [7:0]    ByteEsc = 8'hDB;
    localparam logic [7:0]    EscEnd  = 8'hDC;
    localparam logic [7:0]    EscEsc  = 8'hDD;

    typedef enum logic [1:0] {StHunt, StFrame, StEscp, StDiscard} state_e;

    state_e          r_state, w_state_nx;
    logic [NW-1:0]   r_len, w_len_nx;
    logic            r_hold_v, w_hold_v_nx;
    logic [7:0]      r_hold_d, w_hold_d_nx;
    logic            w_push;
    logic [9:0]      w_push_entry;
    logic            w_start, w_end, w_err;
    logic [1:0]      w_code;
    logic            w_dec;
    logic [7:0]      w_dec_byte;
    logic            w_acc, w_pop, w_in_ready, w_nonempty;

    logic [9:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [LW-1:0]   r_count;
    logic            r_frame_start, r_frame_end, r_frame_error;
    logic [1:0]      r_err_code;

    assign w_nonempty = (r_count != '0);
    assign w_in_ready = (r_count < LW'(DEPTH)) || bus.out_ready;
    assign w_acc      = bus.in_valid && w_in_ready;
    assign w_pop      = bus.out_ready && w_nonempty;

    always_comb begin
        w_state_nx   = r_state;
        w_len_nx     = r_len;
        w_hold_v_nx  = r_hold_v;
        w_hold_d_nx  = r_hold_d;
        w_push       = 1'b0;
        w_push_entry = {2'b00, r_hold_d};
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_err        = 1'b0;
        w_code       = 2'b00;
        w_dec        = 1'b0;
        w_dec_byte   = 8'h00;
        if (w_acc) begin
            unique case (r_state)
                StHunt: begin
                    if (bus.in_data == ByteEnd) w_state_nx = StFrame;
                end
                StFrame: begin
                    if (bus.in_data == ByteEnd) begin
                        // Empty frames close silently.
                        if (r_len != '0) begin
                            w_end        = 1'b1;
                            w_push       = 1'b1;
                            w_push_entry = {2'b01, r_hold_d};
                        end
                        w_hold_v_nx = 1'b0;
                        w_len_nx    = '0;
                    end else if (bus.in_data == ByteEsc) begin
                        w_state_nx = StEscp;
                    end else begin
                        w_dec      = 1'b1;
                        w_dec_byte = bus.in_data;
                    end
                end
                StEscp: begin
                    w_state_nx = StFrame;
                    if (bus.in_data == EscEnd) begin
                        w_dec      = 1'b1;
                        w_dec_byte = ByteEnd;
                    end else if (bus.in_data == EscEsc) begin
                        w_dec      = 1'b1;
                        w_dec_byte = ByteEsc;
                    end else if (bus.in_data == ByteEnd) begin
                        w_err  = 1'b1;
                        w_code = 2'b11;
                    end else begin
                        w_err      = 1'b1;
                        w_code     = 2'b01;
                        w_state_nx = StDiscard;
                    end
                end
                StDiscard: begin
                    if (bus.in_data == ByteEnd) begin
                        w_state_nx = StFrame;
                        w_len_nx   = '0;
                    end
                end
                default: w_state_nx = StHunt;
            endcase

            if (w_dec) begin
                if (r_len == MaxLen) begin
                    w_err      = 1'b1;
                    w_code     = 2'b10;
                    w_state_nx = StDiscard;
                end else begin
                    w_start      = (r_len == '0);
                    w_len_nx     = r_len + NW'(1);
                    w_push       = r_hold_v;
                    w_push_entry = {2'b00, r_hold_d};
                    w_hold_v_nx  = 1'b1;
                    w_hold_d_nx  = w_dec_byte;
                end
            end

            if (w_err) begin
                w_push       = r_hold_v;
                w_push_entry = {2'b11, r_hold_d};
                w_hold_v_nx  = 1'b0;
                w_len_nx     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StHunt;
            r_len         <= '0;
            r_hold_v      <= 1'b0;
            r_hold_d      <= 8'h00;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_error <= 1'b0;
            r_err_code    <= 2'b00;
        end else begin
            r_state       <= w_state_nx;
            r_len         <= w_len_nx;
            r_hold_v      <= w_hold_v_nx;
            r_hold_d      <= w_hold_d_nx;
            r_frame_start <= w_start;
            r_frame_end   <= w_end;
            r_frame_error <= w_err;
            if (w_err) r_err_code <= w_code;
        end
    end

    // Storage needs no reset: head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= w_push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_nonempty;
    assign bus.out_data  = w_nonempty ? r_mem[r_rd][7:0] : 8'h00;
    assign bus.out_last  = w_nonempty & r_mem[r_rd][8];
    assign bus.out_err   = w_nonempty & r_mem[r_rd][9];
    assign frame_start   = r_frame_start;
    assign frame_end     = r_frame_end;
    assign frame_error   = r_frame_error;
    assign err_code      = r_err_code;
    assign fifo_level    = r_count;

`ifdef SLIP_RX_STATS_EN
    logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_end && !(&r_frame_cnt)) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (w_err && !(&r_err_cnt))   r_err_cnt   <= r_err_cnt + CNT_W'(1);
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif
endmodule

// File: tb/tb_slip_rx_fifo.sv
// Randomised and directed bench for slip_rx_fifo against a frame-level SLIP reference model.
module tb_slip_rx_fifo;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LW      = $clog2(DEPTH + 1);
    localparam logic [7:0]  C_END   = 8'hC0;
    localparam logic [7:0]  C_ESC   = 8'hDB;
    localparam logic [7:0]  C_EEND  = 8'hDC;
    localparam logic [7:0]  C_EESC  = 8'hDD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_start, frame_end, frame_error;
    logic [1:0]    err_code;
    logic [LW-1:0] fifo_level;
`ifdef SLIP_RX_STATS_EN
    logic [CNT_W-1:0] frame_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    slip_rx_fifo_if bus ();

    slip_rx_fifo #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .frame_error(frame_error),
        .err_code   (err_code),
        .fifo_level (fifo_level)
`ifdef SLIP_RX_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: whole frames are buffered and emitted when they close or abort.
    bit         m_sync, m_esc, m_drop;
    logic [7:0] m_frm[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int         m_starts, m_ends, m_errs;
    logic [1:0] m_code;
    int         s_starts, s_ends, s_errs;
    int         rdy_mode;

    function automatic void mdl_emit(input bit err);
        for (int i = 0; i < m_frm.size(); i++) begin
            bit last = (i == m_frm.size() - 1);
            exp_q.push_back({err & last, last, m_frm[i]});
        end
        m_frm.delete();
    endfunction

    function automatic void mdl_error(input logic [1:0] code);
        m_errs++;
        m_code = code;
        mdl_emit(1'b1);
    endfunction

    function automatic void mdl_decode(input logic [7:0] b);
        if (m_frm.size() == MAX_LEN) begin
            mdl_error(2'b10);
            m_drop = 1'b1;
        end else begin
            if (m_frm.size() == 0) m_starts++;
            m_frm.push_back(b);
        end
    endfunction

    function automatic void mdl_byte(input logic [7:0] b);
        if (!m_sync) begin
            if (b == C_END) m_sync = 1'b1;
        end else if (m_drop) begin
            if (b == C_END) m_drop = 1'b0;
        end else if (m_esc) begin
            m_esc = 1'b0;
            if (b == C_EEND)      mdl_decode(C_END);
            else if (b == C_EESC) mdl_decode(C_ESC);
            else if (b == C_END)  mdl_error(2'b11);
            else begin
                mdl_error(2'b01);
                m_drop = 1'b1;
            end
        end else if (b == C_END) begin
            if (m_frm.size() > 0) begin
                m_ends++;
                mdl_emit(1'b0);
            end
        end else if (b == C_ESC) begin
            m_esc = 1'b1;
        end else begin
            mdl_decode(b);
        end
    endfunction

    function automatic void mdl_reset();
        m_sync = 0; m_esc = 0; m_drop = 0;
        m_frm.delete(); exp_q.delete(); got_q.delete();
        m_starts = 0; m_ends = 0; m_errs = 0; m_code = 2'b00;
        s_starts = 0; s_ends = 0; s_errs = 0;
    endfunction

    // One clock: drive at negedge, sample #1 later, away from the posedge.
    task automatic cycle(input logic v, input logic [7:0] d, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        #1;
        acc = v && bus.in_ready;
        if (bus.out_valid && bus.out_ready)
            got_q.push_back({bus.out_err, bus.out_last, bus.out_data});
        if (acc) mdl_byte(d);
        s_starts += int'(frame_start);
        s_ends   += int'(frame_end);
        s_errs   += int'(frame_error);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n = 0;
        do begin
            cycle(1'b1, b, acc);
            n++;
        end while (!acc && n < 200);
        chk("send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) cycle(1'b0, 8'h00, acc);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 0;
        idle(1);
        while (bus.out_valid && n < 200) begin
            idle(1);
            n++;
        end
        idle(3);
        chk("drain_empty", bus.out_valid, 0);
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_item"}, got_q[i], exp_q[i]);
        chk({tag, "_starts"}, s_starts, m_starts);
        chk({tag, "_ends"}, s_ends, m_ends);
        chk({tag, "_errs"}, s_errs, m_errs);
        chk({tag, "_err_code"}, err_code, m_code);
`ifdef SLIP_RX_STATS_EN
        chk({tag, "_frame_cnt"}, frame_cnt, m_ends);
        chk({tag, "_err_cnt"}, err_cnt, m_errs);
`endif
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        mdl_reset();
        #1;
        chk("rst_level", fifo_level, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_flags", {bus.out_last, bus.out_err}, 0);
        chk("rst_pulses", {frame_start, frame_end, frame_error}, 0);
        chk("rst_err_code", err_code, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] seq[$];
        logic       acc;
        rdy_mode = 0;
        do_reset();
        idle(1);
        chk("idle_in_ready", bus.in_ready, 1);

        // Plain frame
        seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0};
        send_seq(seq); drain();
        chk("t1_last_byte", exp_q.size() == 3 ? exp_q[2] : 10'h3FF, 10'h103);
        compare("t1_plain");

        // Garbage while hunting, then escapes
        do_reset();
        seq = '{8'h55, 8'hAA, 8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
        send_seq(seq); drain();
        compare("t2_escape");

        // Bad escape then recovery
        seq = '{8'hC0, 8'h11, 8'hDB, 8'h41, 8'h22, 8'hC0, 8'h33, 8'hC0};
        send_seq(seq); drain();
        chk("t3_code_const", err_code, 2'b01);
        compare("t3_bad_esc");

        // Overflow at MAX_LEN
        seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hC0};
        send_seq(seq); drain();
        chk("t4_code_const", err_code, 2'b10);
        compare("t4_overflow");

        // END right after ESC
        seq = '{8'hC0, 8'h05, 8'hDB, 8'hC0, 8'h06, 8'hC0};
        send_seq(seq); drain();
        chk("t5_code_const", err_code, 2'b11);
        compare("t5_esc_end");

        // Fill FIFO with consumer stalled
        rdy_mode = 2;
        seq = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0, 8'h04, 8'h05};
        send_seq(seq);
        cycle(1'b1, 8'h06, acc);
        chk("full_accept", acc, 0);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_level", fifo_level, DEPTH);
        rdy_mode = 0;
        seq = '{8'h06, 8'h07, 8'hC0, 8'h08, 8'h09, 8'h0A, 8'hC0};
        send_seq(seq); drain();
        chk("full_total", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            chk("full_order", got_q[i][7:0], i + 1);
        compare("t6_full");

        // Empty frames are invisible
        seq = '{8'hC0, 8'hC0, 8'hC0};
        send_seq(seq); drain();
        chk("t7_no_output", got_q.size(), 0);
        compare("t7_empty");

        // Reset mid-frame
        seq = '{8'hC0, 8'h01, 8'h02, 8'h03};
        send_seq(seq);
        do_reset();
        seq = '{8'hC0, 8'h07, 8'hC0};
        send_seq(seq); drain();
        chk("t8_after_rst", got_q.size() == 1 ? got_q[0] : 10'h3FF, 10'h107);
        compare("t8_reset");

        // Random stream biased towards SLIP control bytes
        do_reset();
        rdy_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 19);
            logic [7:0] b;
            b = (r < 3) ? C_END : (r < 6) ? C_ESC : (r < 8) ? C_EEND :
                (r < 10) ? C_EESC : 8'($urandom_range(0, 255));
            send_byte(b);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        send_byte(C_END);
        drain();
        compare("t9_random");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
